// File: rtl/mdu_pkg.sv
// Shared MDU constants: MDUOp encodings and the two-state sequencer encoding.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_div.sv
// Combinational signed/unsigned divider with divide-by-zero flag and the
// most-negative / -1 overflow case; zero latency, no flow control.
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend.
  always_comb begin
    a_neg    = is_signed & a[WIDTH-1];
    b_neg    = is_signed & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = (b == '0);
    b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
    if (is_signed && (a == MOST_NEG) && (b == '1)) begin
      quo = MOST_NEG;
      rem = '0;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; result commits MULT_CYCLES or
// DIV_CYCLES after issue. busy is the stall source; start/ops are ignored while busy.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_cycles_check
    $error("mdu: MULT_CYCLES and DIV_CYCLES must lie in 1..15");
  end

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e         state, state_nxt;
  logic [3:0]         cnt;
  logic [WIDTH-1:0]   stage_hi, stage_lo;
  logic               stage_vld;
  logic               is_mul, is_div, issue, mul_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic               div_zero;

  assign is_mul = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
  assign is_div = (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);
  assign issue  = (state == S_IDLE) && start && (is_mul || is_div);

  // Sign-extending to 2*WIDTH makes the low half of an unsigned product the signed product.
  assign mul_signed = (MDUOp == MDU_MULT);
  assign a_ext      = {{WIDTH{mul_signed & A[WIDTH-1]}}, A};
  assign b_ext      = {{WIDTH{mul_signed & B[WIDTH-1]}}, B};
  assign prod       = a_ext * b_ext;

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .a        (A),
    .b        (B),
    .is_signed(MDUOp == MDU_DIV),
    .quo      (div_quo),
    .rem      (div_rem),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue) state_nxt = S_RUN;
      S_RUN:   if (cnt == 4'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI        <= '0;
      LO        <= '0;
      stage_hi  <= '0;
      stage_lo  <= '0;
      stage_vld <= 1'b0;
      cnt       <= '0;
    end else if (state == S_IDLE) begin
      if (issue) begin
        stage_hi  <= is_div ? div_rem : prod[2*WIDTH-1:WIDTH];
        stage_lo  <= is_div ? div_quo : prod[WIDTH-1:0];
        stage_vld <= ~(is_div & div_zero);
        cnt       <= is_div ? DIV_CNT : MULT_CNT;
      end else if (MDUOp == MDU_MTHI) begin
        HI <= A;
      end else if (MDUOp == MDU_MTLO) begin
        LO <= A;
      end
    end else begin
      cnt <= cnt - 4'd1;
      // Divide-by-zero still occupies the unit but leaves HI/LO untouched.
      if (cnt == 4'd1 && stage_vld) begin
        HI <= stage_hi;
        LO <= stage_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
`timescale 1ns/1ps
module tb_mdu;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset, start, busy;
  logic [2:0]   MDUOp;
  logic [W-1:0] A, B, HI, LO;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;
  vec_t tbl [8];

  mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural result of one op, from plain integer arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_MULT:  begin p = 64'(sa * sb); m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; end
      MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; end
      MDU_DIV:   if (b != 0) begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
      MDU_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      MDU_MTHI:  m_hi = a;
      MDU_MTLO:  m_lo = a;
      default:   ;
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb);
    int n_busy, exp_n;
    logic [W-1:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    exp_n  = (op == MDU_DIV || op == MDU_DIVU) ? DC : MC;
    start = 1'b1; MDUOp = op; A = a; B = b;
    step();
    start = 1'b0; MDUOp = MDU_NONE; A = $urandom; B = $urandom;
    n_busy = 0;
    while (busy === 1'b1 && n_busy < 40) begin
      n_busy++;
      chk({name, " hi held"}, HI, old_hi);
      chk({name, " lo held"}, LO, old_lo);
      if (disturb && n_busy == 2) begin
        start = 1'b1; MDUOp = MDU_DIV; A = 32'd100; B = 32'd7;
      end else if (disturb && n_busy == 3) begin
        start = 1'b0; MDUOp = MDU_MTHI; A = 32'h1234;
      end else begin
        start = 1'b0; MDUOp = MDU_NONE;
      end
      step();
    end
    model_op(op, a, b);
    chk({name, " busy cycles"}, W'(n_busy), W'(exp_n));
    chk({name, " hi"}, HI, m_hi);
    chk({name, " lo"}, LO, m_lo);
  endtask

  initial begin
    logic [2:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic         r_start;

    tbl[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    tbl[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{MDU_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[6] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
    tbl[7] = '{MDU_DIV,   32'd5,        32'd0,        32'h0000000F, 32'h0FFFFFFF};

    reset = 1'b1; start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
    step();
    step();
    m_hi = '0;
    m_lo = '0;
    chk("reset busy", W'(busy), '0);
    chk("reset hi", HI, '0);
    chk("reset lo", LO, '0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
      chk($sformatf("vec%0d table hi", i), HI, tbl[i].hi);
      chk($sformatf("vec%0d table lo", i), LO, tbl[i].lo);
    end

    // Restart and MTHI during RUN are both dropped.
    run_op("midrun", MDU_MULT, 32'd3, 32'd4, 1'b1);
    chk("midrun table hi", HI, 32'd0);
    chk("midrun table lo", LO, 32'd12);
    step();
    chk("midrun no restart", W'(busy), '0);

    // Reset on the third busy cycle aborts, dominating a coincident start.
    start = 1'b1; MDUOp = MDU_DIV; A = 32'd100; B = 32'd7;
    step();
    start = 1'b0; MDUOp = MDU_NONE;
    step();
    step();
    chk("abort busy before reset", W'(busy), 32'd1);
    reset = 1'b1; start = 1'b1; MDUOp = MDU_MULT; A = 32'd3; B = 32'd3;
    step();
    reset = 1'b0; start = 1'b0; MDUOp = MDU_NONE;
    m_hi = '0;
    m_lo = '0;
    chk("abort busy", W'(busy), '0);
    chk("abort hi", HI, '0);
    chk("abort lo", LO, '0);
    step();
    chk("abort stays idle", W'(busy), '0);
    chk("abort no commit lo", LO, '0);
    MDUOp = MDU_MTLO; A = 32'h55;
    step();
    MDUOp = MDU_NONE;
    m_lo = 32'h55;
    chk("mtlo after reset lo", LO, 32'h55);
    chk("mtlo after reset hi", HI, '0);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 6));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ((r_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) && $urandom_range(0, 3) != 0) begin
        run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, 1'b0);
      end else begin
        r_start = (r_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) ? 1'b0 : 1'($urandom_range(0, 1));
        start = r_start; MDUOp = r_op; A = r_a; B = r_b;
        step();
        start = 1'b0; MDUOp = MDU_NONE;
        if (r_op == MDU_MTHI || r_op == MDU_MTLO) model_op(r_op, r_a, r_b);
        chk($sformatf("rnd%0d idle busy", i), W'(busy), '0);
        chk($sformatf("rnd%0d idle hi", i), HI, m_hi);
        chk($sformatf("rnd%0d idle lo", i), LO, m_lo);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, busy cycles per mult/multu (legal range 1..15).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles per div/divu (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  E-stage mult/multu/div/divu issue strobe.
REQ-007 SHALL have port MDUOp  input  3  NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 SHALL have port A  input  WIDTH  forwarded rs value.
REQ-009 SHALL have port B  input  WIDTH  forwarded rt value.
REQ-010 SHALL have port busy  output  1  operation in flight, registered.
REQ-011 SHALL have port HI  output  WIDTH  architectural HI register.
REQ-012 SHALL have port LO  output  WIDTH  architectural LO register.

Function
REQ-013 SHALL be in state IDLE or RUN only; busy is 1 exactly in RUN.
REQ-014 SHALL, in IDLE with start=1 and MDUOp in {MULT,MULTU,DIV,DIVU}, sample A/B, compute the result into staging registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN on the next edge.
REQ-015 SHALL keep busy high for exactly N consecutive cycles, N being the loaded count; the counter decrements by one each RUN cycle.
REQ-016 SHALL commit staging to HI/LO on the same edge that returns to IDLE; new HI/LO and busy=0 appear together.
REQ-017 SHALL never change HI/LO during RUN.
REQ-018 SHALL ignore start while busy; no restart and no re-sampling of operands.
REQ-019 SHALL ignore start with MDUOp of NONE, MTHI or MTLO.
REQ-020 SHALL, in IDLE with MDUOp=MTHI (MTLO), write A to HI (LO) on the next edge; start is not required.
REQ-021 SHALL ignore MTHI/MTLO while busy.
REQ-022 SHALL compute MULT as a signed 2*WIDTH product and MULTU as an unsigned one; HI gets the upper half and LO the lower half.
REQ-023 SHALL compute DIV as a signed quotient truncated toward zero into LO; HI gets the remainder, which takes the sign of the dividend.
REQ-024 SHALL compute DIVU as an unsigned quotient into LO and remainder into HI.
REQ-025 SHALL, for DIV with A=most-negative and B=-1, give LO=most-negative and HI=0.
REQ-026 SHALL, when B=0 on DIV/DIVU, still run DIV_CYCLES with busy high and leave HI/LO unchanged at commit.
REQ-027 SHALL provide the pipeline stall term start|busy to external logic; this block does not combine the two internally.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, clear HI, LO, staging registers and counter, set busy=0 and state to IDLE.
REQ-029 SHALL, on reset during RUN, abort the operation with no commit; reset dominates start, MTHI and MTLO in the same cycle.

Structure
REQ-030 SHALL take the MDUOp encodings from the shared constants header, alongside the existing ALUOp/DMOp definitions.
REQ-031 SHALL place signed/unsigned divide with the zero and overflow special cases in one combinational sub-module named mdu_div.
REQ-032 SHALL size the counter as 4 bits and check that both latency parameters lie in 1..15.

Verification
REQ-033 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-035 SHALL cover: DIV A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI/LO unchanged.
REQ-036 SHALL cover: DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 SHALL cover: second start and MTHI 0x1234 issued mid-RUN -> both ignored, first result committed on schedule.
REQ-038 SHALL cover: reset asserted on the 3rd busy cycle -> next cycle busy=0, HI=LO=0; a following MTLO 0x55 -> LO=0x55 one edge later.
